// File: rtl/bounce_motion_ctrl.sv
// Per-frame ball motion sequencer: on each frame tick, steps the ball by the per-axis speed,
// reflects it off the active-area edges, and pulses a per-axis bounce flag.
module bounce_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int BALL_SIZE = 16,
  parameter int X_INIT    = 312,
  parameter int Y_INIT    = 232
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic [2:0] speed_x,
  input  logic [2:0] speed_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       dir_x,
  output logic       dir_y,
  output logic [1:0] bounce,
  output logic [9:0] frame_count,
  output logic       busy
);

  localparam logic [9:0] MAX_X  = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] MAX_Y  = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] INIT_X = 10'(X_INIT);
  localparam logic [9:0] INIT_Y = 10'(Y_INIT);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t     state, state_nxt;
  logic [2:0] spd_x_q, spd_y_q;
  logic [9:0] nx_q, ny_q;
  logic       ndx_q, ndy_q, hit_x_q, hit_y_q;

  // Returns {hit, next_dir, next_pos}; a zero step never bounces, even when parked on an edge.
  function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [2:0] spd, input logic [9:0] lim);
    logic [10:0] sum;
    logic [11:0] res;
    sum = {1'b0, pos} + {8'b0, spd};
    if (spd == 3'd0)
      res = {1'b0, dir, pos};
    else if (dir) begin
      if (sum >= {1'b0, lim}) res = {1'b1, 1'b0, lim};
      else                    res = {1'b0, 1'b1, sum[9:0]};
    end else begin
      if (pos <= {7'b0, spd}) res = {1'b1, 1'b1, 10'd0};
      else                    res = {1'b0, 1'b0, pos - {7'b0, spd}};
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick && !pause) state_nxt = CALC_X;
      CALC_X:  state_nxt = CALC_Y;
      CALC_Y:  state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ball_x      <= INIT_X;
      ball_y      <= INIT_Y;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      bounce      <= 2'b00;
      frame_count <= 10'd0;
      spd_x_q     <= 3'd0;
      spd_y_q     <= 3'd0;
      nx_q        <= INIT_X;
      ny_q        <= INIT_Y;
      ndx_q       <= 1'b1;
      ndy_q       <= 1'b1;
      hit_x_q     <= 1'b0;
      hit_y_q     <= 1'b0;
    end else begin
      bounce <= 2'b00;
      // Every tick counts a frame, whether paused or arriving mid-update.
      if (frame_tick) frame_count <= frame_count + 10'd1;
      case (state)
        IDLE: begin
          if (frame_tick && !pause) begin
            spd_x_q <= speed_x;
            spd_y_q <= speed_y;
          end
        end
        CALC_X: {hit_x_q, ndx_q, nx_q} <= step_axis(ball_x, dir_x, spd_x_q, MAX_X);
        CALC_Y: {hit_y_q, ndy_q, ny_q} <= step_axis(ball_y, dir_y, spd_y_q, MAX_Y);
        COMMIT: begin
          ball_x <= nx_q;
          ball_y <= ny_q;
          dir_x  <= ndx_q;
          dir_y  <= ndy_q;
          bounce <= {hit_y_q, hit_x_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Directed bench for bounce_motion_ctrl: drives ticks on falling edges and checks
// outputs on falling edges against hand-computed trajectories.
module tb_bounce_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       pause;
  logic [2:0] speed_x, speed_y;
  logic [9:0] ball_x, ball_y;
  logic       dir_x, dir_y;
  logic [1:0] bounce;
  logic [9:0] frame_count;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_fc = 0;
  int cur_x  = 312;
  int cur_y  = 232;

  always #5 clk = ~clk;

  bounce_motion_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .pause       (pause),
    .speed_x     (speed_x),
    .speed_y     (speed_y),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .dir_x       (dir_x),
    .dir_y       (dir_y),
    .bounce      (bounce),
    .frame_count (frame_count),
    .busy        (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One full motion frame: tick, check busy and hold-off, then the committed result and bounce width.
  task automatic run_frame(input int sx, input int sy, input int ex, input int ey,
                           input int edx, input int edy, input int eb);
    @(negedge clk);
    speed_x = 3'(sx); speed_y = 3'(sy); frame_tick = 1'b1;
    exp_fc++;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("busy_t1", int'(busy), 1);
    @(negedge clk);
    @(negedge clk);
    chk("busy_t3", int'(busy), 1);
    chk("hold_x", int'(ball_x), cur_x);
    chk("hold_y", int'(ball_y), cur_y);
    @(negedge clk);
    chk("busy_done", int'(busy), 0);
    chk("ball_x", int'(ball_x), ex);
    chk("ball_y", int'(ball_y), ey);
    chk("dir_x", int'(dir_x), edx);
    chk("dir_y", int'(dir_y), edy);
    chk("bounce", int'(bounce), eb);
    chk("frame_count", int'(frame_count), exp_fc);
    @(negedge clk);
    chk("bounce_clr", int'(bounce), 0);
    cur_x = ex;
    cur_y = ey;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; pause = 1'b0; speed_x = 3'd0; speed_y = 3'd0;
    repeat (2) @(negedge clk);
    chk("rst_x", int'(ball_x), 312);
    chk("rst_y", int'(ball_y), 232);
    chk("rst_dir", int'({dir_x, dir_y}), 3);
    chk("rst_bounce", int'(bounce), 0);
    chk("rst_fc", int'(frame_count), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // Normal step
    run_frame(3, 2, 315, 234, 1, 1, 0);

    // Run right to 620, then hit the right edge and come back
    for (int i = 1; i <= 43; i++) run_frame(7, 0, 315 + 7 * i, 234, 1, 1, 0);
    run_frame(4, 0, 620, 234, 1, 1, 0);
    run_frame(5, 0, 624, 234, 0, 1, 1);
    run_frame(5, 0, 619, 234, 0, 1, 0);

    // Travel left to x=2, then down to y=462 with a parked x axis
    for (int i = 1; i <= 88; i++) run_frame(7, 0, 619 - 7 * i, 234, 0, 1, 0);
    run_frame(1, 0, 2, 234, 0, 1, 0);
    for (int i = 1; i <= 32; i++) run_frame(0, 7, 2, 234 + 7 * i, 0, 1, 0);
    run_frame(0, 4, 2, 462, 0, 1, 0);

    // Corner hit on both axes
    run_frame(4, 7, 0, 464, 1, 0, 3);

    // Zero speed while sitting on edges: no bounce, directions kept
    run_frame(0, 0, 0, 464, 1, 0, 0);

    // Pause: ticks count frames but nothing moves
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); frame_tick = 1'b1; speed_x = 3'd7; speed_y = 3'd7; exp_fc++;
      @(negedge clk); frame_tick = 1'b0;
      chk("pause_busy", int'(busy), 0);
      @(negedge clk);
      @(negedge clk);
      chk("pause_bounce", int'(bounce), 0);
      chk("pause_x", int'(ball_x), 0);
      chk("pause_y", int'(ball_y), 464);
    end
    chk("pause_fc", int'(frame_count), exp_fc);
    pause = 1'b0;

    // Overlapping tick one cycle later: counted, not queued
    @(negedge clk); speed_x = 3'd1; speed_y = 3'd1; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    exp_fc += 2;
    @(negedge clk);
    chk("ovl_x", int'(ball_x), 1);
    chk("ovl_y", int'(ball_y), 463);
    chk("ovl_fc", int'(frame_count), exp_fc);
    repeat (6) @(negedge clk);
    chk("ovl_busy", int'(busy), 0);
    chk("ovl_x_once", int'(ball_x), 1);
    chk("ovl_y_once", int'(ball_y), 463);

    // Reset landing in CALC_Y discards the update
    @(negedge clk); speed_x = 3'd5; speed_y = 3'd5; frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_x", int'(ball_x), 312);
    chk("mid_rst_y", int'(ball_y), 232);
    chk("mid_rst_dir", int'({dir_x, dir_y}), 3);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_bounce", int'(bounce), 0);
    chk("mid_rst_fc", int'(frame_count), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_bounce", int'(bounce), 0);
    chk("post_rst_x", int'(ball_x), 312);
    chk("post_rst_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
